// File: rtl/pwm_gen_multi.sv
// pwm_gen_multi: multi-channel PWM generator driven by one shared counter.
//
// Each channel has a double-buffered duty value. Writes land in a shadow
// register and move into the active register only at the period wrap, so
// an output never glitches mid-period. While enable is low, the active
// registers follow the shadows directly.
//
// Parameters:
//   CH    number of channels (1..16)
//   W     duty/counter width (4..16); period is 2^W-1 ticks
//   PRESC clocks per counter tick (1..65535)
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-high reset
//   enable        run control; low holds counter at 0 and forces outputs low
//   wr_en         one-cycle shadow write strobe
//   wr_addr       channel index for the write; indices >= CH are ignored
//   wr_data       duty value for the write
//   pwm_out       registered PWM outputs, bit i = channel i
//   pending       bit i set while shadow[i] holds an unloaded write
//   period_start  one-clk pulse in the cycle after each counter wrap
//
// Build option:
//   PWM_PHASE_STAGGER_EN  when defined, channel i compares against
//                         (cnt + i*(MAX/CH)) mod MAX to spread rising edges.

module pwm_gen_multi #(
    parameter int unsigned CH    = 4,
    parameter int unsigned W     = 8,
    parameter int unsigned PRESC = 1,
    localparam int unsigned AW   = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    output logic [CH-1:0] pwm_out,
    output logic [CH-1:0] pending,
    output logic          period_start
);

    localparam int unsigned MAX = (2 ** W) - 1;
    localparam int unsigned PW  = (PRESC > 1) ? $clog2(PRESC) : 1;

    // Registered state
    logic [PW-1:0] pc_q;
    logic [W-1:0]  cnt_q;
    logic [W-1:0]  shadow_q [CH];
    logic [W-1:0]  active_q [CH];
    logic [CH-1:0] pending_q;
    logic [CH-1:0] pwm_q;
    logic          ps_q;

    // Next-state values
    logic [PW-1:0] pc_d;
    logic [W-1:0]  cnt_d;
    logic [W-1:0]  shadow_d [CH];
    logic [W-1:0]  active_d [CH];
    logic [CH-1:0] pending_d;
    logic [CH-1:0] pwm_d;
    logic          ps_d;

    // Combinational helpers
    logic          tick_c;
    logic          load_c;
    logic          wr_hit_c;
    logic          reload_c;
    logic [W-1:0]  cnt_ch_c [CH];

    // Counter advances on the last prescaler cycle; the wrap is the load event
    assign tick_c   = enable && (pc_q == PW'(PRESC - 1));
    assign load_c   = tick_c && (cnt_q == W'(MAX - 1));
    assign wr_hit_c = wr_en && (32'(wr_addr) < CH);
    // Active registers take the shadows on a wrap, or every cycle while stopped
    assign reload_c = !enable || load_c;

    // Per-channel compare count
    for (genvar gi = 0; gi < CH; gi++) begin : g_cmp
`ifdef PWM_PHASE_STAGGER_EN
        localparam int unsigned OFF = gi * (MAX / CH);
        logic [W:0] sum_c;

        // OFF < MAX and cnt < MAX, so one conditional subtract gives the modulo
        always_comb begin
            sum_c = {1'b0, cnt_q} + (W+1)'(OFF);
            if (sum_c >= (W+1)'(MAX)) begin
                cnt_ch_c[gi] = W'(sum_c - (W+1)'(MAX));
            end else begin
                cnt_ch_c[gi] = W'(sum_c);
            end
        end
`else
        always_comb begin
            cnt_ch_c[gi] = cnt_q;
        end
`endif
    end

    // Next-state logic
    always_comb begin
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        pwm_d     = '0;
        ps_d      = load_c;

        // Prescaler and period counter
        if (!enable) begin
            pc_d  = '0;
            cnt_d = '0;
        end else if (tick_c) begin
            pc_d  = '0;
            cnt_d = load_c ? '0 : cnt_q + W'(1);
        end else begin
            pc_d  = pc_q + PW'(1);
        end

        // Shadow to active transfer
        if (reload_c) begin
            active_d  = shadow_q;
            pending_d = '0;
        end

        // A write coinciding with a reload bypasses straight into active
        if (wr_hit_c) begin
            shadow_d[wr_addr] = wr_data;
            if (reload_c) begin
                active_d[wr_addr] = wr_data;
            end else begin
                pending_d[wr_addr] = 1'b1;
            end
        end

        // Output compare from the current count and active duty
        for (int i = 0; i < int'(CH); i++) begin
            pwm_d[i] = enable && (cnt_ch_c[i] < active_q[i]);
        end
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= '0;
            cnt_q     <= '0;
            pending_q <= '0;
            pwm_q     <= '0;
            ps_q      <= 1'b0;
            for (int i = 0; i < int'(CH); i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            pwm_q     <= pwm_d;
            ps_q      <= ps_d;
            for (int i = 0; i < int'(CH); i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    assign pwm_out      = pwm_q;
    assign pending      = pending_q;
    assign period_start = ps_q;

endmodule

// File: doc/pwm_gen_multi.md
# pwm_gen_multi

Parametrised multi-channel PWM generator, successor to the fixed four-channel 8-bit generator in the RGBW lamp. It drives CH LED channels from one shared counter. Duty values are double-buffered so updates from the SPI/colour path take effect only at a period boundary, which avoids glitches. It sits between the colour generator and the output pins, clocked by the system clock, and uses an internal prescaler in place of a separate divider block.

## Interface
- CH, default 4: number of PWM channels (1..16).
- W, default 8: duty/counter width in bits (4..16).
- PRESC, default 1: clock cycles per counter tick (1..65535). A value of 1 means every cycle.
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run control. Low holds the counter and forces outputs low.
- wr_en  in  1  one-cycle write strobe for a shadow duty register.
- wr_addr  in  max(1,$clog2(CH))  channel index. Indices >= CH are ignored.
- wr_data  in  W  duty value.
- pwm_out  out  CH  registered PWM outputs, bit i = channel i.
- pending  out  CH  bit i = 1 when shadow[i] has been written but not yet loaded.
- period_start  out  1  one-clk pulse on each counter wrap to 0.

## Operation
- MAX = 2^W - 1. The counter cnt runs 0..MAX-1, so the period is MAX ticks (255 for W=8).
- Prescaler pc runs 0..PRESC-1. A tick occurs when enable=1 and pc==PRESC-1. pc resets to 0 on each tick and is held at 0 while enable=0.
- On each tick, cnt increments. When cnt==MAX-1 it wraps to 0. This wrap is the "load event".
- Compare: channel i is high when cnt_i < active[i], with cnt_i = cnt (see Configuration).
  - duty 0 gives constant low.
  - duty MAX gives constant high.
  - duty d gives d high ticks per period.
- Write: when wr_en=1 and wr_addr<CH, shadow[wr_addr] <= wr_data and pending[wr_addr] <= 1.
- Load event: active[j] <= shadow[j] for all j, and pending is cleared to 0.
- Write in the same cycle as a load event: the written value bypasses into active[wr_addr] and pending stays 0.
- enable=0: cnt=0, pc=0, pwm_out=0. active tracks shadow every cycle, pending is 0, and writes are still accepted.
- period_start is registered and pulses in the cycle after the load event.

## Timing
- Reset values:
  - cnt=0, pc=0.
  - shadow=0, active=0.
  - pwm_out=0, pending=0, period_start=0.
- Reset acts asynchronously and immediately. Release is synchronous to the next clk edge.
- pwm_out[i] is registered from the current cnt/active, so it lags the counter by 1 clk.
- Write-to-pending latency is 1 clk.
- Write-to-output latency is at most one full period (MAX*PRESC clks) plus 1 clk.
- After enable rises: the first tick occurs PRESC clks later. pwm_out for a nonzero duty goes high on the first edge with enable=1, because the compare uses cnt=0.
- Reset asserted mid-period:
  - outputs drop immediately;
  - shadow contents are lost;
  - the next period starts from cnt=0.
- Reset takes precedence over wr_en in the same cycle.
- A write with wr_addr >= CH, or with wr_en low, changes no state.

## Configuration
- PWM_PHASE_STAGGER_EN defined: channel i compares cnt_i = (cnt + i*(MAX/CH)) mod MAX, using integer division. For W=8, CH=4 the offsets are 0, 63, 126, 189. This spreads rising edges to reduce peak supply current. The load event and period_start still follow the unshifted cnt.
- Not defined: all channels compare against cnt directly, so every channel's rising edge falls at cnt=0. The stagger adder logic is not synthesised.

## Test plan
- CH=4, W=8, PRESC=1: apply reset, release it, hold enable=0 for 10 clks -> pwm_out=0, pending=0, period_start=0 throughout.
- enable=0; write ch0=64 and ch1=255; then set enable=1 -> per 255-clk period, ch0 is high for 64 clks and ch1 is high for all 255. ch2 and ch3 stay low. period_start pulses every 255 clks.
- Running with ch0=64: write ch0=128 at cnt=100 -> pending[0]=1 until the wrap. The current period keeps 64 high clks, the next period has 128, and pending[0] returns to 0 on the load event.
- Write ch2=10 in the exact cycle of the load event (cnt==254, tick) -> pending[2] stays 0 and ch2 shows 10 high clks in the immediately following period.
- PRESC=3, ch0=2 -> period is 765 clks, with ch0 high for 6 clks. Writing wr_addr=5 with CH=4 changes nothing.
- Assert reset at cnt=50 with outputs high -> pwm_out goes to 0 within the same cycle (asynchronous). After release with enable=1, all outputs are low because duties are reset to 0. With PWM_PHASE_STAGGER_EN and all duties 10, the channels' rising edges fall at cnt = 0, 192, 129, 66.
